// File: rtl/parallel_bus_master_if.sv
// Bus-side signals of the 8-bit parallel bus: tristate data, direction, phase select, enable/ack.
// The master modport drives the strobes; the slave modport is the responder's view.
interface parallel_bus_master_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] bus_o;
  logic [WIDTH-1:0] bus_i;
  logic             bus_t;
  logic             read;
  logic             register_select;
  logic             enable;
  logic             ack_valid;

  modport master (
    output bus_o, bus_t, read, register_select, enable,
    input  bus_i, ack_valid
  );

  modport slave (
    input  bus_o, bus_t, read, register_select, enable,
    output bus_i, ack_valid
  );
endinterface

// File: rtl/parallel_bus_master.sv
// Initiator for the parallel bus: address phase, then MSB-first data phases with a four-phase
// enable/ack handshake. Define PARALLEL_BUS_MASTER_READBACK_CHECK_EN to verify writes by readback.
module parallel_bus_master #(
  parameter int unsigned WIDTH                 = 8,
  parameter int unsigned TRANSACTIONS_PER_WORD = 2,
  parameter int unsigned SETUP_CYCLES          = 2,
  parameter int unsigned ACK_TIMEOUT_CYCLES    = 1000
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   cmd_read,
  input  logic [WIDTH-1:0]                       cmd_address,
  input  logic [TRANSACTIONS_PER_WORD*WIDTH-1:0] cmd_write_data,
  output logic                                   busy,
  output logic                                   done,
  output logic [TRANSACTIONS_PER_WORD*WIDTH-1:0] read_data_word,
  output logic                                   timeout_error,
  output logic [31:0]                            error_count,
  output logic                                   mismatch,
  parallel_bus_master_if.master                  bus_if
);

  localparam int unsigned WordW = TRANSACTIONS_PER_WORD * WIDTH;
  localparam int unsigned IdxW  = (TRANSACTIONS_PER_WORD > 1) ? $clog2(TRANSACTIONS_PER_WORD) : 1;
  localparam int unsigned SetW  = $clog2(SETUP_CYCLES + 1);
  localparam int unsigned ToW   = $clog2(ACK_TIMEOUT_CYCLES + 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(TRANSACTIONS_PER_WORD - 1);
  localparam logic [SetW-1:0] SetupLast = SetW'(SETUP_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast    = ToW'(ACK_TIMEOUT_CYCLES - 1);

`ifdef PARALLEL_BUS_MASTER_READBACK_CHECK_EN
  localparam bit ReadbackEn = 1'b1;
`else
  localparam bit ReadbackEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StRelease, StDone} state_e;
  state_e state_q, state_d;

  logic             ack_meta_q, ack_s_q;
  logic [WIDTH-1:0] bus_q;
  logic             cmd_read_q, cmd_read_d;
  logic [WordW-1:0] wdata_q, wdata_d;
  logic [WordW-1:0] rdata_q, rdata_d;
  logic [IdxW-1:0]  index_q, index_d;
  logic             addr_phase_q, addr_phase_d;
  logic             rb_q, rb_d;
  logic [SetW-1:0]  setup_cnt_q, setup_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             terr_q, terr_d, mism_q, mism_d;
  logic [31:0]      err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] bus_o_q, bus_o_d;
  logic             bus_t_q, bus_t_d, read_q, read_d, rs_q, rs_d, enable_q, enable_d;

  logic             abort, finish, rb_next, next_read;
  logic [IdxW-1:0]  index_nx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      ack_meta_q   <= 1'b0;
      ack_s_q      <= 1'b0;
      bus_q        <= '0;
      cmd_read_q   <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      index_q      <= IdxLast;
      addr_phase_q <= 1'b1;
      rb_q         <= 1'b0;
      setup_cnt_q  <= '0;
      to_cnt_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
      mism_q       <= 1'b0;
      err_cnt_q    <= '0;
      bus_o_q      <= '0;
      bus_t_q      <= 1'b1;
      read_q       <= 1'b0;
      rs_q         <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_meta_q   <= bus_if.ack_valid;
      ack_s_q      <= ack_meta_q;
      bus_q        <= bus_if.bus_i;
      cmd_read_q   <= cmd_read_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      index_q      <= index_d;
      addr_phase_q <= addr_phase_d;
      rb_q         <= rb_d;
      setup_cnt_q  <= setup_cnt_d;
      to_cnt_q     <= to_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      terr_q       <= terr_d;
      mism_q       <= mism_d;
      err_cnt_q    <= err_cnt_d;
      bus_o_q      <= bus_o_d;
      bus_t_q      <= bus_t_d;
      read_q       <= read_d;
      rs_q         <= rs_d;
      enable_q     <= enable_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_read_d   = cmd_read_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    index_d      = index_q;
    addr_phase_d = addr_phase_q;
    rb_d         = rb_q;
    setup_cnt_d  = setup_cnt_q;
    to_cnt_d     = to_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    terr_d       = terr_q;
    mism_d       = mism_q;
    err_cnt_d    = err_cnt_q;
    bus_o_d      = bus_o_q;
    bus_t_d      = bus_t_q;
    read_d       = read_q;
    rs_d         = rs_q;
    enable_d     = enable_q;
    abort        = 1'b0;
    finish       = 1'b0;
    // Readback starts once the last write part has been handshaken.
    rb_next   = ReadbackEn && !cmd_read_q && !rb_q && !addr_phase_q && (index_q == '0);
    next_read = cmd_read_q || rb_q || rb_next;
    index_nx  = (addr_phase_q || rb_next) ? IdxLast : index_q - IdxW'(1);

    case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) state_d = StIdle;
        if (start) begin
          cmd_read_d   = cmd_read;
          wdata_d      = cmd_write_data;
          index_d      = IdxLast;
          addr_phase_d = 1'b1;
          rb_d         = 1'b0;
          busy_d       = 1'b1;
          terr_d       = 1'b0;
          mism_d       = 1'b0;
          rs_d         = 1'b0;
          read_d       = 1'b0;
          bus_t_d      = 1'b0;
          bus_o_d      = cmd_address;
          setup_cnt_d  = '0;
          state_d      = StSetup;
        end
      end
      StSetup: begin
        if (setup_cnt_q != SetupLast) begin
          setup_cnt_d = setup_cnt_q + SetW'(1);
        end else if (!ack_s_q) begin
          enable_d = 1'b1;
          to_cnt_d = '0;
          state_d  = StStrobe;
        end
      end
      StStrobe: begin
        if (ack_s_q) begin
          enable_d = 1'b0;
          if (!addr_phase_q && read_q) rdata_d[index_q*WIDTH +: WIDTH] = bus_q;
          to_cnt_d = '0;
          state_d  = StRelease;
        end else if (to_cnt_q == ToLast) begin
          abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StRelease: begin
        if (!ack_s_q) begin
          if (!addr_phase_q && (index_q == '0) && !rb_next) begin
            finish = 1'b1;
            mism_d = ReadbackEn && rb_q && (rdata_q != wdata_q);
          end else if (next_read && !bus_t_q) begin
            // Turn the bus around a full cycle before read rises.
            bus_t_d = 1'b1;
            bus_o_d = '0;
          end else begin
            addr_phase_d = 1'b0;
            index_d      = index_nx;
            rb_d         = rb_q || rb_next;
            rs_d         = 1'b1;
            read_d       = next_read;
            bus_t_d      = next_read;
            bus_o_d      = next_read ? '0 : wdata_q[index_nx*WIDTH +: WIDTH];
            setup_cnt_d  = '0;
            state_d      = StSetup;
          end
        end else if (to_cnt_q == ToLast) begin
          abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      terr_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
    end
    // read drops here; bus_t can only return to 0 on a later accepted start.
    if (abort || finish) begin
      state_d  = StDone;
      done_d   = 1'b1;
      busy_d   = 1'b0;
      enable_d = 1'b0;
      read_d   = 1'b0;
      rs_d     = 1'b0;
      bus_t_d  = 1'b1;
      bus_o_d  = '0;
      index_d  = IdxLast;
    end
  end

  always_comb begin
    busy                   = busy_q;
    done                   = done_q;
    read_data_word         = rdata_q;
    timeout_error          = terr_q;
    error_count            = err_cnt_q;
    mismatch               = mism_q;
    bus_if.bus_o           = bus_o_q;
    bus_if.bus_t           = bus_t_q;
    bus_if.read            = read_q;
    bus_if.register_select = rs_q;
    bus_if.enable          = enable_q;
  end

endmodule
